// File: rtl/tlb_multiport_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tlb_multiport_if : entry type package and lookup-port bus          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+

package tlb_multiport_pkg;

    // ASID field is sized for the widest MIPS32 ASID; narrower ASID_W uses the low bits.
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

endpackage

interface tlb_lookup_if #(
    parameter int LOOKUP_PORTS = 2,
    parameter int IDX_W        = 4,
    parameter int ASID_W       = 8
);
    logic [LOOKUP_PORTS-1:0]       lk_valid;
    logic [32*LOOKUP_PORTS-1:0]    lk_vaddr;
    logic [ASID_W-1:0]             cur_asid;
    logic [LOOKUP_PORTS-1:0]       res_valid;
    logic [32*LOOKUP_PORTS-1:0]    res_paddr;
    logic [LOOKUP_PORTS-1:0]       res_miss;
    logic [LOOKUP_PORTS-1:0]       res_v;
    logic [LOOKUP_PORTS-1:0]       res_d;
    logic [LOOKUP_PORTS-1:0]       res_multi;
    logic [3*LOOKUP_PORTS-1:0]     res_c;
    logic [IDX_W*LOOKUP_PORTS-1:0] res_index;

    modport master (
        output lk_valid, lk_vaddr, cur_asid,
        input  res_valid, res_paddr, res_miss, res_v, res_d, res_multi, res_c, res_index
    );

    modport slave (
        input  lk_valid, lk_vaddr, cur_asid,
        output res_valid, res_paddr, res_miss, res_v, res_d, res_multi, res_c, res_index
    );
endinterface

`default_nettype wire

// File: rtl/tlb_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tlb_multiport : fully associative MIPS32 JTLB, N lookup ports      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+

module tlb_multiport
    import tlb_multiport_pkg::*;
#(
    parameter int ENTRIES      = 16,
    parameter int LOOKUP_PORTS = 2,
    parameter int ASID_W       = 8,
    localparam int IDX_W       = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    tlb_lookup_if.slave       lk,
    input  logic              wr_en,
    input  logic              wr_rand,
    input  logic [IDX_W-1:0]  wr_index,
    input  tlb_entry_t        wr_entry,
    input  logic [IDX_W-1:0]  rd_index,
    output tlb_entry_t        rd_entry,
    input  logic              probe_req,
    input  logic [31:0]       probe_hi,
    output logic [31:0]       probe_index,
    input  logic              wired_we,
    input  logic [IDX_W-1:0]  wired_wdata,
    output logic [IDX_W-1:0]  random
);

    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(ENTRIES - 1);
    localparam logic [31:0]      PROBE_MISS = 32'h8000_0000;

    tlb_entry_t              r_entries [ENTRIES];
    logic [ENTRIES-1:0]      r_present;
    logic [IDX_W-1:0]        r_wired;
    logic [IDX_W-1:0]        r_random;

    logic [ENTRIES-1:0]      w_match [LOOKUP_PORTS];
    logic [LOOKUP_PORTS-1:0] w_hit;
    logic [LOOKUP_PORTS-1:0] w_multi;
    logic [IDX_W-1:0]        w_idx   [LOOKUP_PORTS];
    logic [31:0]             w_paddr [LOOKUP_PORTS];
    logic [2:0]              w_c     [LOOKUP_PORTS];
    logic [LOOKUP_PORTS-1:0] w_v;
    logic [LOOKUP_PORTS-1:0] w_d;

    logic [ENTRIES-1:0]      w_probe_match;
    logic                    w_probe_hit;
    logic [IDX_W-1:0]        w_probe_idx;
    logic                    w_probe_unused;

    assign w_probe_unused = ^probe_hi[12:ASID_W];
    assign rd_entry       = r_entries[rd_index];
    assign random         = r_random;

    function automatic logic f_match(input tlb_entry_t e, input logic present,
                                     input logic [18:0] vpn2, input logic [ASID_W-1:0] asid);
        return present && (e.vpn2 == vpn2) && (e.g || (e.asid[ASID_W-1:0] == asid));
    endfunction

    // Match and priority-select per port; lowest matching index wins.
    always_comb begin
        tlb_entry_t sel;
        logic       page;
        logic [31:0] vaddr;
        sel = '0;
        page = 1'b0;
        vaddr = '0;
        for (int p = 0; p < LOOKUP_PORTS; p++) begin
            vaddr = lk.lk_vaddr[32*p +: 32];
            for (int e = 0; e < ENTRIES; e++) begin
                w_match[p][e] = f_match(r_entries[e], r_present[e], vaddr[31:13], lk.cur_asid);
            end
            w_hit[p]   = |w_match[p];
            w_multi[p] = |(w_match[p] & (w_match[p] - ENTRIES'(1)));
            w_idx[p]   = '0;
            for (int e = ENTRIES - 1; e >= 0; e--) begin
                if (w_match[p][e]) begin
                    w_idx[p] = IDX_W'(e);
                end
            end
            sel  = r_entries[w_idx[p]];
            page = vaddr[12];
            w_paddr[p] = '0;
            w_c[p]     = '0;
            w_v[p]     = 1'b0;
            w_d[p]     = 1'b0;
            if (w_hit[p]) begin
                w_paddr[p] = {(page ? sel.pfn1 : sel.pfn0), vaddr[11:0]};
                w_c[p]     = page ? sel.c1 : sel.c0;
                w_v[p]     = page ? sel.v1 : sel.v0;
                w_d[p]     = page ? sel.d1 : sel.d0;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            w_probe_match[e] = f_match(r_entries[e], r_present[e], probe_hi[31:13],
                                       probe_hi[ASID_W-1:0]);
        end
        w_probe_hit = |w_probe_match;
        w_probe_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (w_probe_match[e]) begin
                w_probe_idx = IDX_W'(e);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lk.res_valid <= '0;
            lk.res_paddr <= '0;
            lk.res_miss  <= '0;
            lk.res_v     <= '0;
            lk.res_d     <= '0;
            lk.res_multi <= '0;
            lk.res_c     <= '0;
            lk.res_index <= '0;
        end else begin
            lk.res_valid <= lk.lk_valid;
            for (int p = 0; p < LOOKUP_PORTS; p++) begin
                if (lk.lk_valid[p]) begin
                    lk.res_paddr[32*p +: 32]       <= w_paddr[p];
                    lk.res_miss[p]                 <= ~w_hit[p];
                    lk.res_v[p]                    <= w_v[p];
                    lk.res_d[p]                    <= w_d[p];
                    lk.res_multi[p]                <= w_multi[p];
                    lk.res_c[3*p +: 3]             <= w_c[p];
                    lk.res_index[IDX_W*p +: IDX_W] <= w_idx[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            probe_index <= PROBE_MISS;
        end else if (probe_req) begin
            probe_index <= w_probe_hit ? {{(32-IDX_W){1'b0}}, w_probe_idx} : PROBE_MISS;
        end
    end

    // TLBWI takes precedence over TLBWR when both are requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_present <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                r_entries[e] <= '0;
            end
        end else if (wr_en) begin
            r_entries[wr_index] <= wr_entry;
            r_present[wr_index] <= 1'b1;
        end else if (wr_rand) begin
            r_entries[r_random] <= wr_entry;
            r_present[r_random] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wired  <= '0;
            r_random <= TOP_IDX;
        end else if (wired_we) begin
            r_wired  <= wired_wdata;
            r_random <= TOP_IDX;
        end else if (r_random <= r_wired) begin
            r_random <= TOP_IDX;
        end else begin
            r_random <= r_random - IDX_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlb_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tlb_multiport : directed self-checking bench for tlb_multiport  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+

module tb_tlb_multiport;
    import tlb_multiport_pkg::*;

    localparam int ENTRIES = 16;
    localparam int LP      = 2;
    localparam int ASID_W  = 8;
    localparam int IDX_W   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en, wr_rand, probe_req, wired_we;
    logic [IDX_W-1:0] wr_index, rd_index, wired_wdata, random;
    tlb_entry_t       wr_entry, rd_entry;
    logic [31:0]      probe_hi, probe_index;

    int n_checks = 0;
    int n_fail   = 0;

    tlb_lookup_if #(.LOOKUP_PORTS(LP), .IDX_W(IDX_W), .ASID_W(ASID_W)) lk_bus ();

    tlb_multiport #(.ENTRIES(ENTRIES), .LOOKUP_PORTS(LP), .ASID_W(ASID_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .lk          (lk_bus),
        .wr_en       (wr_en),
        .wr_rand     (wr_rand),
        .wr_index    (wr_index),
        .wr_entry    (wr_entry),
        .rd_index    (rd_index),
        .rd_entry    (rd_entry),
        .probe_req   (probe_req),
        .probe_hi    (probe_hi),
        .probe_index (probe_index),
        .wired_we    (wired_we),
        .wired_wdata (wired_wdata),
        .random      (random)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                      input logic g, input logic [19:0] pfn0,
                                      input logic [2:0] c0, input logic d0, input logic v0,
                                      input logic [19:0] pfn1, input logic [2:0] c1,
                                      input logic d1, input logic v1);
        tlb_entry_t e;
        e.vpn2 = vpn2; e.asid = asid; e.g = g;
        e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
        e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
        return e;
    endfunction

    initial begin
        tlb_entry_t e_a, e_f, e_g, e_h, e_new;
        logic [IDX_W-1:0] rseq [14];

        e_a   = mk(19'h00400, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b1);
        e_f   = mk(19'h00123, 8'd1, 1'b1, 20'hAAAAA, 3'd1, 1'b0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
        e_g   = mk(19'h00555, 8'd0, 1'b1, 20'h0BEEF, 3'd5, 1'b0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
        e_h   = mk(19'h00666, 8'd0, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
        e_new = mk(19'h00400, 8'd5, 1'b1, 20'h77777, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b1);

        reset = 1'b1; wr_en = 1'b0; wr_rand = 1'b0; probe_req = 1'b0; wired_we = 1'b0;
        wr_index = '0; rd_index = '0; wired_wdata = '0; wr_entry = '0; probe_hi = '0;
        lk_bus.lk_valid = '0; lk_bus.lk_vaddr = '0; lk_bus.cur_asid = '0;
        tick(); tick();

        check("rst_res_valid", lk_bus.res_valid, 2'b00);
        check("rst_res_paddr", lk_bus.res_paddr, 64'h0);
        check("rst_probe", probe_index, 32'h8000_0000);
        check("rst_random", random, 4'd15);

        // Empty TLB: every lookup and probe misses.
        reset = 1'b0; lk_bus.lk_valid = 2'b11; probe_req = 1'b1;
        tick();
        probe_req = 1'b0;
        check("empty_valid", lk_bus.res_valid, 2'b11);
        check("empty_miss", lk_bus.res_miss, 2'b11);
        check("empty_paddr", lk_bus.res_paddr, 64'h0);
        check("empty_probe", probe_index, 32'h8000_0000);

        // TLBWI index 3, then both pages looked up.
        lk_bus.lk_valid = 2'b00; wr_en = 1'b1; wr_index = 4'd3; wr_entry = e_a;
        tick();
        wr_en = 1'b0;
        lk_bus.cur_asid = 8'd5; lk_bus.lk_valid = 2'b11;
        lk_bus.lk_vaddr = {32'h0080_1ABC, 32'h0080_0ABC};
        check("idle_valid", lk_bus.res_valid, 2'b00);
        tick();
        check("hit_valid", lk_bus.res_valid, 2'b11);
        check("hit_miss", lk_bus.res_miss, 2'b00);
        check("hit_paddr", lk_bus.res_paddr, {32'h5432_1ABC, 32'h1234_5ABC});
        check("hit_v", lk_bus.res_v, 2'b11);
        check("hit_d", lk_bus.res_d, 2'b01);
        check("hit_c", lk_bus.res_c, 6'b010_011);
        check("hit_index", lk_bus.res_index, 8'h33);
        check("hit_multi", lk_bus.res_multi, 2'b00);

        // Idle port keeps its last result.
        lk_bus.lk_valid = 2'b00; lk_bus.lk_vaddr = '0;
        tick();
        check("hold_valid", lk_bus.res_valid, 2'b00);
        check("hold_paddr", lk_bus.res_paddr, {32'h5432_1ABC, 32'h1234_5ABC});

        // ASID mismatch on a non-global entry.
        lk_bus.cur_asid = 8'd6; lk_bus.lk_valid = 2'b01; lk_bus.lk_vaddr = {32'h0, 32'h0080_0ABC};
        tick();
        check("asid_miss", lk_bus.res_miss, 2'b01);
        check("asid_paddr", lk_bus.res_paddr[31:0], 32'h0);
        check("asid_v", lk_bus.res_v[0], 1'b0);
        check("asid_c", lk_bus.res_c[2:0], 3'd0);
        check("asid_index", lk_bus.res_index[3:0], 4'd0);

        // Global rewrite hits under any ASID.
        lk_bus.lk_valid = 2'b00; wr_en = 1'b1; e_a.g = 1'b1; wr_entry = e_a;
        tick();
        wr_en = 1'b0; lk_bus.lk_valid = 2'b01;
        probe_req = 1'b1; probe_hi = 32'h0080_0005;
        tick();
        check("glob_miss", lk_bus.res_miss[0], 1'b0);
        check("glob_paddr", lk_bus.res_paddr[31:0], 32'h1234_5ABC);
        check("probe_hit", probe_index, 32'h0000_0003);
        probe_hi = 32'h0100_0005;
        tick();
        check("probe_miss", probe_index, 32'h8000_0000);
        probe_req = 1'b0; probe_hi = 32'h0080_0005;
        tick();
        check("probe_hold", probe_index, 32'h8000_0000);

        // Duplicate entries at 9 and 2: lowest index wins, multi flagged.
        lk_bus.lk_valid = 2'b00; wr_en = 1'b1; wr_entry = e_f; wr_index = 4'd9;
        tick();
        wr_index = 4'd2;
        tick();
        wr_en = 1'b0; lk_bus.lk_valid = 2'b11;
        lk_bus.lk_vaddr = {32'h0024_6000, 32'h0080_0ABC};
        tick();
        check("multi_index", lk_bus.res_index, 8'h23);
        check("multi_flag", lk_bus.res_multi, 2'b10);
        check("multi_paddr", lk_bus.res_paddr[63:32], 32'hAAAA_A000);

        // Write and lookup in the same cycle see the old entry.
        lk_bus.lk_valid = 2'b01; wr_en = 1'b1; wr_index = 4'd3; wr_entry = e_new; rd_index = 4'd3;
        #1;
        check("rd_prewrite", rd_entry, e_a);
        tick();
        wr_en = 1'b0;
        check("wr_same_old", lk_bus.res_paddr[31:0], 32'h1234_5ABC);
        tick();
        check("wr_next_new", lk_bus.res_paddr[31:0], 32'h7777_7ABC);
        check("rd_postwrite", rd_entry, e_new);

        // Wired = 4: Random walks 15..4 then wraps; TLBWR lands at 7.
        lk_bus.lk_valid = 2'b00; wired_we = 1'b1; wired_wdata = 4'd4;
        tick();
        wired_we = 1'b0; wr_entry = e_g;
        for (int i = 0; i < 12; i++) rseq[i] = IDX_W'(15 - i);
        rseq[12] = 4'd15; rseq[13] = 4'd14;
        for (int i = 0; i < 14; i++) begin
            check($sformatf("random_%0d", i), random, rseq[i]);
            wr_rand = (i == 8);
            tick();
            wr_rand = 1'b0;
        end
        rd_index = 4'd7;
        lk_bus.lk_valid = 2'b01; lk_bus.lk_vaddr = {32'h0, 32'h00AA_A123};
        #1;
        check("tlbwr_rd", rd_entry, e_g);
        tick();
        check("tlbwr_paddr", lk_bus.res_paddr[31:0], 32'h0BEE_F123);
        check("tlbwr_index", lk_bus.res_index[3:0], 4'd7);

        // Wired at the top pins Random; wr_en beats wr_rand.
        lk_bus.lk_valid = 2'b00; wired_we = 1'b1; wired_wdata = 4'd15;
        tick();
        wired_we = 1'b0;
        check("wired_top_a", random, 4'd15);
        wr_en = 1'b1; wr_rand = 1'b1; wr_index = 4'd0; wr_entry = e_h;
        tick();
        wr_en = 1'b0; wr_rand = 1'b0;
        check("wired_top_b", random, 4'd15);
        rd_index = 4'd0;
        #1;
        check("both_wr_idx", rd_entry, e_h);
        rd_index = 4'd15;
        #1;
        check("both_wr_rand", rd_entry, 128'h0);

        // Reset mid-operation discards in-flight results and clears the array.
        lk_bus.lk_valid = 2'b01; lk_bus.lk_vaddr = {32'h0, 32'h00AA_A123};
        probe_req = 1'b1; reset = 1'b1;
        tick();
        check("mid_rst_valid", lk_bus.res_valid, 2'b00);
        check("mid_rst_paddr", lk_bus.res_paddr, 64'h0);
        check("mid_rst_probe", probe_index, 32'h8000_0000);
        check("mid_rst_random", random, 4'd15);
        reset = 1'b0;
        tick();
        probe_req = 1'b0;
        check("post_rst_miss", lk_bus.res_miss[0], 1'b1);
        rd_index = 4'd7;
        #1;
        check("post_rst_rd", rd_entry, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tlb_multiport.md
Name: tlb_multiport

Overview:
- Parametrised, fully associative MIPS32 joint TLB with LOOKUP_PORTS independent translation ports (fetch, load/store, ...).
- Supports TLBP/TLBR/TLBWI plus TLBWR, using an internal Random counter bounded by a Wired register.
- Sits between the MMU front ends and CP0.
- Lookups and probes are registered (1-cycle latency); TLBR is combinational.

Parameters:
- ENTRIES, 16, number of entries; power of two, 4..64; IDX_W = $clog2(ENTRIES).
- LOOKUP_PORTS, 2, number of translation ports, 1..4.
- ASID_W, 8, ASID width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- lk_valid  in  LOOKUP_PORTS  per-port lookup request
- lk_vaddr  in  32*LOOKUP_PORTS  per-port virtual address; port p = bits [32p+31:32p]
- cur_asid  in  ASID_W  current ASID from EntryHi
- res_valid  out  LOOKUP_PORTS  registered lk_valid
- res_paddr  out  32*LOOKUP_PORTS  translated address
- res_miss / res_v / res_d / res_multi  out  LOOKUP_PORTS each  miss, valid bit, dirty bit, multiple-match flag
- res_c  out  3*LOOKUP_PORTS  cache attribute
- res_index  out  IDX_W*LOOKUP_PORTS  matching entry index
- wr_en  in  1  TLBWI: write entry wr_index
- wr_rand  in  1  TLBWR: write entry at Random
- wr_index  in  IDX_W  TLBWI target index
- wr_entry  in  tlb_entry_t  entry data (c0, c1, asid, vpn2, pfn0/1, d0/v0/d1/v1, G)
- rd_index  in  IDX_W  TLBR index
- rd_entry  out  tlb_entry_t  combinational read of entry rd_index
- probe_req  in  1  TLBP request
- probe_hi  in  32  EntryHi for probe: VPN2 = [31:13], ASID = [ASID_W-1:0]
- probe_index  out  32  Index register value; bit31 = P
- wired_we  in  1  write Wired register
- wired_wdata  in  IDX_W  new Wired value
- random  out  IDX_W  current Random register

Behaviour:
- Storage: ENTRIES x tlb_entry_t plus a per-entry present bit.
- Reset: all present bits = 0, entry data = 0, wired = 0, random = ENTRIES-1, every res_* = 0, probe_index = 0x8000_0000.
- An entry matches when present && vpn2 == vaddr[31:13] && (G || asid == cur_asid).
- Non-present entries never match.
- Lookup (per port, independent): outputs register on the clk edge after lk_valid.
  - res_valid <= lk_valid, every cycle.
  - Hit: res_index = lowest matching index.
  - Page select uses vaddr[12]: 0 selects pfn0/c0/d0/v0; 1 selects pfn1/c1/d1/v1.
  - res_paddr = {pfn[19:0], vaddr[11:0]}; res_miss = 0.
  - Miss: res_miss = 1; res_paddr, res_v, res_d, res_c, res_index = 0.
  - res_multi = 1 when more than one entry matches; the result still comes from the lowest index.
  - If lk_valid = 0, all other res_* fields of that port hold their previous values.
- Probe: one cycle after probe_req, probe_index updates.
  - Hit: {1'b0, zero-extend(lowest matching index)}.
  - Miss: 0x8000_0000.
  - Without probe_req, probe_index holds.
- Write: on the clk edge with wr_en, entry[wr_index] <= wr_entry and present <= 1.
- wr_rand writes entry[random] the same way.
- If wr_en and wr_rand are both asserted, wr_en wins and Random still steps.
- Read-vs-write ordering: a lookup, probe or TLBR in the same cycle as a write sees the pre-write array. The write is visible to requests issued the next cycle.
- Random: steps every cycle.
  - Next value is ENTRIES-1 if random <= wired, else random-1.
  - Random is therefore confined to [wired, ENTRIES-1].
  - wired_we: wired <= wired_wdata and random <= ENTRIES-1 on the same edge, overriding the step.
  - If wired_wdata = ENTRIES-1, random stays at ENTRIES-1.
- Reset mid-operation: in-flight lookup/probe results are discarded; the next cycle shows reset values.

Test Plan:
- Reset, then lk_valid on both ports with vaddr 0x0000_0000 -> res_valid = 1, res_miss = 1, res_paddr = 0; probe_index = 0x8000_0000; random = 15.
- TLBWI index 3: vpn2 = 0x00400, asid = 5, G = 0, pfn0 = 0x12345 (v0 = 1, d0 = 1, c0 = 3), pfn1 = 0x54321 (v1 = 1, d1 = 0). Then cur_asid = 5:
  - port0 vaddr 0x0080_0ABC -> paddr 0x1234_5ABC, v = 1, d = 1, c = 3, index = 3.
  - port1 vaddr 0x0080_1ABC -> paddr 0x5432_1ABC, d = 0.
  - Both results arrive 1 cycle later.
- Same entry with cur_asid = 6 -> miss. Rewrite with G = 1 -> hit. probe_hi 0x0080_0005 -> probe_index 3; probe_hi 0x0100_0005 -> 0x8000_0000.
- wired_we with 4 -> random sequence 15,14,...,4,15,14 across consecutive cycles. TLBWR when random = 7 -> rd_index 7 returns the written entry.
- Identical entries written at indices 2 and 9 -> lookup gives res_index = 2, res_multi = 1.
- Same cycle: TLBWI of new pfn at index 3 plus lookup -> old paddr. Lookup on the next cycle -> new paddr.
